// File: rtl/memu.sv
// MEM stage of the rv32i pipeline: EX/MEM register, valid/ready data-bus requests, store lane
// alignment and load extension. Optional macro MEMU_MISALIGN_TRAP_EN suppresses misaligned accesses.
module memu #(
    parameter int XLEN   = 32,
    parameter int STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        i_mnemonic,
    input  logic [4:0]        i_rd_addr,
    input  logic              i_rd_wr,
    input  logic [XLEN-1:0]   i_ALUout,
    input  logic [XLEN-1:0]   i_rs2_data,
    input  logic              i_DM_OE,
    input  logic              i_store,
    input  logic [2:0]        i_funct3,
    output logic              o_dm_valid,
    output logic              o_dm_we,
    output logic [XLEN-1:0]   o_dm_addr,
    output logic [STRB_W-1:0] o_dm_wstrb,
    output logic [XLEN-1:0]   o_dm_wdata,
    input  logic              i_dm_ready,
    input  logic              i_dm_rvalid,
    input  logic [XLEN-1:0]   i_dm_rdata,
    output logic [4:0]        o_rd_addr,
    output logic [XLEN-1:0]   o_rd_data,
    output logic              o_rd_wr,
    output logic [4:0]        o_mem_rd_addr,
    output logic [XLEN-1:0]   o_mem_rd_data,
    output logic              o_mem_rd_wr,
    output logic              o_mem_stall,
    output logic              o_misalign
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RESP} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [5:0]        r_mnemonic;
    logic [4:0]        r_rd_addr;
    logic              r_rd_wr;
    logic [XLEN-1:0]   r_alu;
    logic [XLEN-1:0]   r_rs2;
    logic              r_dm_oe;
    logic              r_store;
    logic [2:0]        r_funct3;

    logic              w_misalign;
    logic              w_mem_req;
    logic              w_done;
    logic              w_stall;
    logic              w_rd_nz;
    logic [STRB_W-1:0] w_wstrb;
    logic [XLEN-1:0]   w_wdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [XLEN-1:0]   w_load;
    logic              w_unused_mnemonic;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_mnemonic <= '0;
            r_rd_addr  <= '0;
            r_rd_wr    <= 1'b0;
            r_alu      <= '0;
            r_rs2      <= '0;
            r_dm_oe    <= 1'b0;
            r_store    <= 1'b0;
            r_funct3   <= '0;
        end else begin
            r_state <= w_state_next;
            if (!w_stall) begin
                r_mnemonic <= i_mnemonic;
                r_rd_addr  <= i_rd_addr;
                r_rd_wr    <= i_rd_wr;
                r_alu      <= i_ALUout;
                r_rs2      <= i_rs2_data;
                r_dm_oe    <= i_DM_OE;
                r_store    <= i_store;
                r_funct3   <= i_funct3;
            end
        end
    end

`ifdef MEMU_MISALIGN_TRAP_EN
    assign w_misalign = (r_dm_oe | r_store) &
                        (((r_funct3[1:0] == 2'b01) & r_alu[0]) |
                         ((r_funct3[1:0] == 2'b10) & (|r_alu[1:0])));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_mem_req = (r_dm_oe | r_store) & ~w_misalign;
    assign w_done    = (r_state == S_RESP) & i_dm_rvalid;
    // Completion cycle releases the stall so the next instruction is captured on the same edge.
    assign w_stall   = w_mem_req & ~w_done;
    assign w_rd_nz   = |r_rd_addr;

    always_comb begin
        w_state_next = r_state;
        o_dm_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_dm_valid = w_mem_req;
                if (w_mem_req) begin
                    w_state_next = i_dm_ready ? S_RESP : S_ADDR;
                end
            end
            S_ADDR: begin
                o_dm_valid = 1'b1;
                if (i_dm_ready) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (i_dm_rvalid) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_wstrb = '0;
        w_wdata = r_rs2;
        case (r_funct3[1:0])
            2'b00: begin
                w_wstrb = STRB_W'(1) << r_alu[1:0];
                w_wdata = {4{r_rs2[7:0]}};
            end
            2'b01: begin
                w_wstrb = STRB_W'(3) << {r_alu[1], 1'b0};
                w_wdata = {2{r_rs2[15:0]}};
            end
            default: w_wstrb = '1;
        endcase
        if (!r_store) begin
            w_wstrb = '0;
        end
    end

    assign w_byte = i_dm_rdata[{r_alu[1:0], 3'b000} +: 8];
    assign w_half = r_alu[1] ? i_dm_rdata[31:16] : i_dm_rdata[15:0];

    always_comb begin
        w_load = i_dm_rdata;
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'b0, w_byte};
            3'b101:  w_load = {16'b0, w_half};
            default: w_load = i_dm_rdata;
        endcase
    end

    assign w_unused_mnemonic = ^r_mnemonic;

    assign o_dm_we       = r_store;
    assign o_dm_addr     = {r_alu[XLEN-1:2], 2'b00};
    assign o_dm_wstrb    = w_wstrb;
    assign o_dm_wdata    = w_wdata;
    assign o_rd_addr     = r_rd_addr;
    assign o_rd_data     = r_dm_oe ? w_load : r_alu;
    assign o_rd_wr       = r_rd_wr & w_rd_nz & ~r_store & ~w_misalign & (~r_dm_oe | w_done);
    assign o_mem_rd_addr = r_rd_addr;
    assign o_mem_rd_data = r_alu;
    assign o_mem_rd_wr   = r_rd_wr & w_rd_nz & ~r_dm_oe & ~r_store;
    assign o_mem_stall   = w_stall;
    assign o_misalign    = w_misalign;
endmodule

// File: tb/tb_memu.sv
// Bench for memu: a per-instruction timeline model (occupancy = ready wait + accept + response wait)
// checked every cycle, plus literal lane/extension values taken from the worked examples.
module tb_memu;
`ifdef MEMU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  i_mnemonic;
    logic [4:0]  i_rd_addr;
    logic        i_rd_wr;
    logic [31:0] i_ALUout;
    logic [31:0] i_rs2_data;
    logic        i_DM_OE;
    logic        i_store;
    logic [2:0]  i_funct3;
    logic        o_dm_valid;
    logic        o_dm_we;
    logic [31:0] o_dm_addr;
    logic [3:0]  o_dm_wstrb;
    logic [31:0] o_dm_wdata;
    logic        i_dm_ready;
    logic        i_dm_rvalid;
    logic [31:0] i_dm_rdata;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic        o_rd_wr;
    logic [4:0]  o_mem_rd_addr;
    logic [31:0] o_mem_rd_data;
    logic        o_mem_rd_wr;
    logic        o_mem_stall;
    logic        o_misalign;

    memu dut (
        .clk(clk), .rst(rst),
        .i_mnemonic(i_mnemonic), .i_rd_addr(i_rd_addr), .i_rd_wr(i_rd_wr),
        .i_ALUout(i_ALUout), .i_rs2_data(i_rs2_data), .i_DM_OE(i_DM_OE),
        .i_store(i_store), .i_funct3(i_funct3),
        .o_dm_valid(o_dm_valid), .o_dm_we(o_dm_we), .o_dm_addr(o_dm_addr),
        .o_dm_wstrb(o_dm_wstrb), .o_dm_wdata(o_dm_wdata),
        .i_dm_ready(i_dm_ready), .i_dm_rvalid(i_dm_rvalid), .i_dm_rdata(i_dm_rdata),
        .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data), .o_rd_wr(o_rd_wr),
        .o_mem_rd_addr(o_mem_rd_addr), .o_mem_rd_data(o_mem_rd_data),
        .o_mem_rd_wr(o_mem_rd_wr), .o_mem_stall(o_mem_stall), .o_misalign(o_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  mn;
        logic [4:0]  rd;
        logic        rd_wr;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic        oe;
        logic        st;
        logic [2:0]  f3;
        int          rdy_wait;
        int          rsp_wait;
        logic [31:0] rdata;
        logic [2:0]  lit;
        logic [3:0]  l_wstrb;
        logic [31:0] l_wdata;
        logic [31:0] l_rd;
        logic [31:0] l_addr;
        bit          spur;
        bit          rst_resp;
    } ins_t;

    ins_t tab[$];
    ins_t bubble;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   chk_en = 1'b0;

    logic        e_valid, e_we, e_rd_chk, e_rd_wr, e_mrd_wr, e_stall, e_mis;
    logic [31:0] e_addr, e_wdata, e_rd_data, e_mrd_data;
    logic [3:0]  e_wstrb;
    logic [4:0]  e_rd_addr;
    bit          l_w, l_rd, l_a, l_zero;
    logic [3:0]  l_wstrb_v;
    logic [31:0] l_wdata_v, l_rd_v, l_addr_v;

    function automatic ins_t mk(input logic [5:0] mn, input logic [4:0] rd, input logic rd_wr,
                                input logic [31:0] alu, input logic [31:0] rs2, input logic oe,
                                input logic st, input logic [2:0] f3, input int rw, input int dw,
                                input logic [31:0] rdata);
        ins_t t;
        t.mn = mn; t.rd = rd; t.rd_wr = rd_wr; t.alu = alu; t.rs2 = rs2;
        t.oe = oe; t.st = st; t.f3 = f3; t.rdy_wait = rw; t.rsp_wait = dw; t.rdata = rdata;
        t.lit = 3'b000; t.l_wstrb = 4'h0; t.l_wdata = 32'h0; t.l_rd = 32'h0; t.l_addr = 32'h0;
        t.spur = 1'b0; t.rst_resp = 1'b0;
        return t;
    endfunction

    function automatic int sz_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit is_mis(input ins_t t);
        int a4;
        a4 = int'(t.alu[1:0]);
        return (t.oe || t.st) && ((a4 % sz_of(t.f3)) != 0);
    endfunction

    function automatic bit is_mem(input ins_t t);
        return (t.oe || t.st) && !(TRAP && is_mis(t));
    endfunction

    function automatic int occ(input ins_t t);
        return is_mem(t) ? (t.rdy_wait + 1 + t.rsp_wait) : 1;
    endfunction

    // Expected outputs while instruction t sits in MEM, cycle c of its n-cycle occupancy.
    task automatic set_exp(input ins_t t, input int c, input int n);
        bit          mis, mem, last;
        int          sz, a4, off;
        logic [63:0] mask;
        logic [31:0] v;
        mis  = TRAP && is_mis(t);
        mem  = is_mem(t);
        last = (c == n - 1);
        sz   = sz_of(t.f3);
        a4   = int'(t.alu[1:0]);
        off  = (sz == 4) ? 0 : a4 - (a4 % sz);
        mask = (64'd1 << (8 * sz)) - 64'd1;
        e_valid = mem && (c <= t.rdy_wait);
        e_we    = t.st;
        e_addr  = t.alu & 32'hFFFF_FFFC;
        e_wstrb = t.st ? 4'(((1 << sz) - 1) << off) : 4'h0;
        for (int i = 0; i < 4; i++) e_wdata[8*i +: 8] = t.rs2[8*(i % sz) +: 8];
        v = 32'((64'(t.rdata) >> (8 * off)) & mask);
        if (sz < 4 && !t.f3[2] && v[8*sz-1]) v = v | ~32'(mask);
        e_rd_data  = t.oe ? v : t.alu;
        e_rd_chk   = !t.oe || (mem && last);
        e_rd_addr  = t.rd;
        e_rd_wr    = t.rd_wr && (t.rd != 5'd0) && !t.st && !mis && (!t.oe || last);
        e_mrd_wr   = t.rd_wr && (t.rd != 5'd0) && !t.oe && !t.st;
        e_mrd_data = t.alu;
        e_stall    = mem && !last;
        e_mis      = mis;
        l_w  = t.lit[0] && mem && (c == 0);
        l_rd = t.lit[1] && mem && last;
        l_a  = t.lit[2] && mem && (c == 0);
        l_wstrb_v = t.l_wstrb; l_wdata_v = t.l_wdata; l_rd_v = t.l_rd; l_addr_v = t.l_addr;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dm_valid", 32'(o_dm_valid), 32'(e_valid));
            chk("mem_stall", 32'(o_mem_stall), 32'(e_stall));
            chk("misalign", 32'(o_misalign), 32'(e_mis));
            chk("rd_addr", 32'(o_rd_addr), 32'(e_rd_addr));
            chk("rd_wr", 32'(o_rd_wr), 32'(e_rd_wr));
            chk("mem_rd_addr", 32'(o_mem_rd_addr), 32'(e_rd_addr));
            chk("mem_rd_data", o_mem_rd_data, e_mrd_data);
            chk("mem_rd_wr", 32'(o_mem_rd_wr), 32'(e_mrd_wr));
            if (e_rd_chk) chk("rd_data", o_rd_data, e_rd_data);
            if (e_valid) begin
                chk("dm_we", 32'(o_dm_we), 32'(e_we));
                chk("dm_addr", o_dm_addr, e_addr);
                chk("dm_wstrb", 32'(o_dm_wstrb), 32'(e_wstrb));
                if (e_we) chk("dm_wdata", o_dm_wdata, e_wdata);
            end
            if (l_w) begin
                chk("lit_wstrb", 32'(o_dm_wstrb), 32'(l_wstrb_v));
                chk("lit_wdata", o_dm_wdata, l_wdata_v);
            end
            if (l_rd) chk("lit_rd_data", o_rd_data, l_rd_v);
            if (l_a) chk("lit_addr", o_dm_addr, l_addr_v);
            if (l_zero) begin
                chk("zero_addr", o_dm_addr, 32'h0);
                chk("zero_wstrb", 32'(o_dm_wstrb), 32'h0);
                chk("zero_wdata", o_dm_wdata, 32'h0);
                chk("zero_we", 32'(o_dm_we), 32'h0);
                chk("zero_rd_data", o_rd_data, 32'h0);
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic drive_ex(input ins_t t);
        i_mnemonic = t.mn; i_rd_addr = t.rd; i_rd_wr = t.rd_wr; i_ALUout = t.alu;
        i_rs2_data = t.rs2; i_DM_OE = t.oe; i_store = t.st; i_funct3 = t.f3;
    endtask

    initial begin
        ins_t t, cur, nxt;
        int   n, cycles;
        bit   mem;
        bubble = mk(6'd0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 0, 0, 32'h0);

        t = mk(6'd1, 5'd0, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0, 1'b1, 3'b010, 0, 1, 32'h0);
        t.lit = 3'b101; t.l_wstrb = 4'hF; t.l_wdata = 32'hDEADBEEF; t.l_addr = 32'h100;
        tab.push_back(t);                                                     // SW
        t = mk(6'd2, 5'd0, 1'b0, 32'h103, 32'h000000AB, 1'b0, 1'b1, 3'b000, 0, 1, 32'h0);
        t.lit = 3'b001; t.l_wstrb = 4'b1000; t.l_wdata = 32'hABABABAB;
        tab.push_back(t);                                                     // SB
        t = mk(6'd3, 5'd5, 1'b1, 32'h103, 32'h0, 1'b1, 1'b0, 3'b000, 0, 2, 32'h80000000);
        t.lit = 3'b010; t.l_rd = 32'hFFFFFF80;
        tab.push_back(t);                                                     // LB
        t = mk(6'd4, 5'd6, 1'b1, 32'h103, 32'h0, 1'b1, 1'b0, 3'b100, 1, 1, 32'h80000000);
        t.lit = 3'b010; t.l_rd = 32'h00000080;
        tab.push_back(t);                                                     // LBU
        t = mk(6'd5, 5'd0, 1'b0, 32'h202, 32'h1234ABCD, 1'b0, 1'b1, 3'b001, 3, 1, 32'h0);
        t.lit = 3'b001; t.l_wstrb = 4'b1100; t.l_wdata = 32'hABCDABCD; t.spur = 1'b1;
        tab.push_back(t);                                                     // SH, ready late
        tab.push_back(mk(6'd6, 5'd7, 1'b1, 32'h11111111, 32'h0, 1'b0, 1'b0, 3'b000, 0, 0, 32'h0));
        t = mk(6'd7, 5'd8, 1'b1, 32'h300, 32'h0, 1'b1, 1'b0, 3'b010, 0, 1, 32'hCAFEF00D);
        t.lit = 3'b010; t.l_rd = 32'hCAFEF00D;
        tab.push_back(t);                                                     // LW
        tab.push_back(mk(6'd6, 5'd9, 1'b1, 32'h22222222, 32'h0, 1'b0, 1'b0, 3'b000, 0, 0, 32'h0));
        t = mk(6'd8, 5'd10, 1'b1, 32'h302, 32'h0, 1'b1, 1'b0, 3'b001, 0, 1, 32'h80017FFF);
        t.lit = 3'b010; t.l_rd = 32'hFFFF8001;
        tab.push_back(t);                                                     // LH
        t = mk(6'd9, 5'd11, 1'b1, 32'h300, 32'h0, 1'b1, 1'b0, 3'b101, 2, 3, 32'h8001FFFE);
        t.lit = 3'b010; t.l_rd = 32'h0000FFFE;
        tab.push_back(t);                                                     // LHU
        tab.push_back(mk(6'd6, 5'd0, 1'b1, 32'h00000033, 32'h0, 1'b0, 1'b0, 3'b000, 0, 0, 32'h0));
        t = mk(6'd7, 5'd12, 1'b1, 32'h102, 32'h0, 1'b1, 1'b0, 3'b010, 0, 1, 32'h12345678);
        t.lit = 3'b110; t.l_rd = 32'h12345678; t.l_addr = 32'h100;
        tab.push_back(t);                                                     // LW misaligned
        tab.push_back(mk(6'd3, 5'd0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 3'b000, 0, 1, 32'h000000FF));
        tab.push_back(mk(6'd6, 5'd13, 1'b1, 32'h00000044, 32'h0, 1'b0, 1'b0, 3'b000, 0, 0, 32'h0));
        t = mk(6'd7, 5'd14, 1'b1, 32'h400, 32'h0, 1'b1, 1'b0, 3'b010, 0, 5, 32'h55555555);
        t.rst_resp = 1'b1;
        tab.push_back(t);                                                     // LW, reset in RESP

        rst = 1'b0;
        drive_ex(bubble);
        i_dm_ready = 1'b0; i_dm_rvalid = 1'b0; i_dm_rdata = 32'h0;
        l_w = 0; l_rd = 0; l_a = 0; l_zero = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        for (int k = -1; k < tab.size(); k++) begin
            cur    = (k < 0) ? bubble : tab[k];
            nxt    = (k + 1 < tab.size()) ? tab[k + 1] : bubble;
            mem    = is_mem(cur);
            n      = occ(cur);
            cycles = cur.rst_resp ? 2 : n;
            for (int c = 0; c < cycles; c++) begin
                drive_ex(nxt);
                i_dm_ready  = mem && (c == cur.rdy_wait);
                i_dm_rvalid = mem && ((c == cur.rdy_wait + cur.rsp_wait) ||
                                      (cur.spur && c < cur.rdy_wait));
                i_dm_rdata  = (mem && cur.oe) ? cur.rdata : $urandom;
                rst         = !(cur.rst_resp && c == 1);
                set_exp(cur, c, n);
                l_zero = (k < 0);
                chk_en = 1'b1;
                @(posedge clk);
                #1;
            end
            $display("txn %0d mnem=%0d rd=%0d addr=%h cycles=%0d checks=%0d errors=%0d",
                     k, cur.mn, cur.rd, cur.alu, cycles, checks, errors);
        end

        // After the reset in RESP: a late rvalid must be ignored, then a plain op flows through.
        t = mk(6'd6, 5'd15, 1'b1, 32'h00000077, 32'h0, 1'b0, 1'b0, 3'b000, 0, 0, 32'h0);
        rst = 1'b1;
        drive_ex(t);
        i_dm_ready = 1'b0; i_dm_rvalid = 1'b1; i_dm_rdata = 32'hFFFFFFFF;
        set_exp(bubble, 0, 1);
        l_zero = 1'b1;
        @(posedge clk);
        #1;
        $display("txn post-reset rvalid ignored checks=%0d errors=%0d", checks, errors);
        drive_ex(bubble);
        i_dm_rvalid = 1'b0;
        set_exp(t, 0, 1);
        l_zero = 1'b0;
        @(posedge clk);
        #1;
        $display("txn post-reset add rd=%0d checks=%0d errors=%0d", t.rd, checks, errors);
        chk_en = 1'b0;
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
